// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake bundle for router_pkt_fifo; master drives the write side and
// read request, slave is the FIFO. Parity ports exist only with ROUTER_FIFO_PARITY_EN.
interface router_pkt_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             soft_reset;
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             rd_first;
  logic             rd_last;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [CW-1:0]    occupancy;
  logic [CW-1:0]    pkt_count;
  logic             overflow;
  logic             underflow;
`ifdef ROUTER_FIFO_PARITY_EN
  logic             parity_err;
  logic             parity_err_seen;

  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  data_out, rd_valid, rd_first, rd_last, full, empty, almost_full,
    input  occupancy, pkt_count, overflow, underflow, parity_err, parity_err_seen
  );
  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output data_out, rd_valid, rd_first, rd_last, full, empty, almost_full,
    output occupancy, pkt_count, overflow, underflow, parity_err, parity_err_seen
  );
`else
  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  data_out, rd_valid, rd_first, rd_last, full, empty, almost_full,
    input  occupancy, pkt_count, overflow, underflow
  );
  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output data_out, rd_valid, rd_first, rd_last, full, empty, almost_full,
    output occupancy, pkt_count, overflow, underflow
  );
`endif
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO with header tagging, packet-boundary tracking on read
// and sticky error flags. Optional per-entry even parity under ROUTER_FIFO_PARITY_EN.
module router_pkt_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input logic         clock,
  input logic         reset,
  router_pkt_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = WIDTH - 1;
`ifdef ROUTER_FIFO_PARITY_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH + 1;
`endif

  typedef enum logic {HDR, BODY} rd_state_e;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    wr_word, rd_word;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d, pkt_q, pkt_d;
  logic [RW-1:0]    rem_q, rem_d;
  rd_state_e        state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full, empty, wr_acc, rd_acc, tag_wr;
`ifdef ROUTER_FIFO_PARITY_EN
  logic             perr_q, perr_d, pseen_q, pseen_d;
  assign wr_word = {^bus.data_in, bus.lfd_state, bus.data_in};
`else
  assign wr_word = {bus.lfd_state, bus.data_in};
`endif

  assign full    = (occ_q == CW'(DEPTH));
  assign empty   = (occ_q == '0);
  assign wr_acc  = bus.write_enb && !full;
  assign rd_acc  = bus.read_enb && !empty;
  assign tag_wr  = wr_acc && bus.lfd_state;
  assign rd_word = mem[rd_ptr_q];

  // Storage carries no reset; flushed contents are simply unreachable.
  always_ff @(posedge clock) begin
    if (wr_acc && !bus.soft_reset) mem[wr_ptr_q] <= wr_word;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    rem_d    = rem_q;
    state_d  = state_q;
    dout_d   = dout_q;
    valid_d  = rd_acc;
    first_d  = 1'b0;
    last_d   = 1'b0;
    ovf_d    = ovf_q | (bus.write_enb & full);
    unf_d    = unf_q | (bus.read_enb & empty);
`ifdef ROUTER_FIFO_PARITY_EN
    perr_d   = rd_acc && ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH+1]);
    pseen_d  = pseen_q | perr_d;
`endif
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = rd_word[WIDTH-1:0];
      // A tagged word always (re)starts a packet, even one that truncates the current body.
      if (rd_word[WIDTH]) begin
        rem_d   = RW'(rd_word[WIDTH-1:2]) + 1'b1;
        first_d = 1'b1;
        state_d = BODY;
      end else if (state_q == BODY) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == RW'(1)) begin
          last_d  = 1'b1;
          state_d = HDR;
        end
      end
    end
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_acc && !rd_acc)      occ_d = occ_q + 1'b1;
    else if (!wr_acc && rd_acc) occ_d = occ_q - 1'b1;
    if (tag_wr && !last_d && pkt_q != CW'(DEPTH)) pkt_d = pkt_q + 1'b1;
    else if (!tag_wr && last_d && pkt_q != '0)    pkt_d = pkt_q - 1'b1;
    if (bus.soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      pkt_d    = '0;
      rem_d    = '0;
      state_d  = HDR;
      dout_d   = '0;
      valid_d  = 1'b0;
      first_d  = 1'b0;
      last_d   = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
`ifdef ROUTER_FIFO_PARITY_EN
      perr_d   = 1'b0;
      pseen_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      rem_q    <= '0;
      state_q  <= HDR;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef ROUTER_FIFO_PARITY_EN
      perr_q   <= 1'b0;
      pseen_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      rem_q    <= rem_d;
      state_q  <= state_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef ROUTER_FIFO_PARITY_EN
      perr_q   <= perr_d;
      pseen_q  <= pseen_d;
`endif
    end
  end

  assign bus.data_out    = dout_q;
  assign bus.rd_valid    = valid_q;
  assign bus.rd_first    = first_q;
  assign bus.rd_last     = last_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (occ_q >= CW'(AFULL_LVL));
  assign bus.occupancy   = occ_q;
  assign bus.pkt_count   = pkt_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
`ifdef ROUTER_FIFO_PARITY_EN
  assign bus.parity_err      = perr_q;
  assign bus.parity_err_seen = pseen_q;
`endif
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomised and directed bench for router_pkt_fifo against a queue-based packet model.
module tb_router_pkt_fifo;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  router_pkt_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
  router_pkt_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Model: queue of {tag, data}; m_rem counts words left in the current packet (0 = awaiting header).
  logic [W:0]   q[$];
  int           m_rem, m_pkt;
  logic [W-1:0] m_dout;
  bit           m_valid, m_first, m_last, m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_rem = 0; m_pkt = 0; m_dout = '0;
    m_valid = 0; m_first = 0; m_last = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic check_all();
    check("data_out",    32'(bus.data_out),    32'(m_dout));
    check("rd_valid",    32'(bus.rd_valid),    32'(m_valid));
    check("rd_first",    32'(bus.rd_first),    32'(m_first));
    check("rd_last",     32'(bus.rd_last),     32'(m_last));
    check("occupancy",   32'(bus.occupancy),   32'(q.size()));
    check("pkt_count",   32'(bus.pkt_count),   32'(m_pkt));
    check("full",        32'(bus.full),        32'(q.size() == D));
    check("empty",       32'(bus.empty),       32'(q.size() == 0));
    check("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
    check("overflow",    32'(bus.overflow),    32'(m_ovf));
    check("underflow",   32'(bus.underflow),   32'(m_unf));
`ifdef ROUTER_FIFO_PARITY_EN
    check("parity_err",  32'(bus.parity_err),  32'd0);
`endif
  endtask

  // Called just after a falling edge: drive, advance one cycle, compare at the next falling edge.
  task automatic step(input bit we, input bit lfd, input logic [W-1:0] din, input bit re, input bit sr);
    bit         was_full, was_empty, wacc, racc, tagw;
    logic [W:0] w;
    bus.write_enb = we; bus.lfd_state = lfd; bus.data_in = din;
    bus.read_enb = re; bus.soft_reset = sr;
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (sr) begin
      model_clear();
    end else begin
      wacc = we && !was_full;
      racc = re && !was_empty;
      tagw = wacc && lfd;
      if (we && was_full) m_ovf = 1;
      if (re && was_empty) m_unf = 1;
      m_valid = racc; m_first = 0; m_last = 0;
      if (racc) begin
        w = q.pop_front();
        m_dout = w[W-1:0];
        if (w[W]) begin
          m_rem = int'(w[W-1:2]) + 1;
          m_first = 1;
        end else if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_last = 1;
        end
      end
      if (wacc) q.push_back({lfd, din});
      if (tagw && !m_last && m_pkt < D) m_pkt++;
      else if (!tagw && m_last && m_pkt > 0) m_pkt--;
    end
    @(posedge clock);
    @(negedge clock);
    $display("t=%0t we=%0b lfd=%0b din=%02h re=%0b sr=%0b | dout=%02h v=%0b f=%0b l=%0b occ=%0d pkt=%0d ovf=%0b unf=%0b",
             $time, we, lfd, din, re, sr, bus.data_out, bus.rd_valid, bus.rd_first, bus.rd_last,
             bus.occupancy, bus.pkt_count, bus.overflow, bus.underflow);
    check_all();
  endtask

  task automatic wr(input bit lfd, input logic [W-1:0] din);
    step(1'b1, lfd, din, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  logic [W-1:0] pkt_a[5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [W-1:0] pkt_t[5] = '{8'h0D, 8'h11, 8'h05, 8'hAA, 8'hBB};

  initial begin
    bus.soft_reset = 0; bus.write_enb = 0; bus.lfd_state = 0;
    bus.data_in = '0; bus.read_enb = 0;
    model_clear();
    #1 reset = 1'b1;
    #1 check_all();
    @(negedge clock);
    reset = 1'b0;

    // Single complete packet: header len 3, three payload words, parity word.
    for (int i = 0; i < 5; i++) wr(i == 0, pkt_a[i]);
    for (int i = 0; i < 5; i++) rd();

    // Fill to full, overflow attempt, simultaneous at full, then wrap with simultaneous ops at 8.
    for (int i = 0; i < D; i++) wr(1'b0, 8'h40 + 8'(i));
    wr(1'b0, 8'hEE);
    step(1'b1, 1'b0, 8'hEF, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) rd();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h80 + 8'(i), 1'b1, 1'b0);
    while (q.size() > 0) rd();
    rd();

    // Soft reset mid-packet at occupancy 6 beats a concurrent write.
    wr(1'b1, 8'h1C);
    for (int i = 0; i < 5; i++) wr(1'b0, 8'h60 + 8'(i));
    step(1'b1, 1'b1, 8'h0D, 1'b0, 1'b1);
    wr(1'b1, 8'h05); wr(1'b0, 8'h71); wr(1'b0, 8'h72);
    for (int i = 0; i < 3; i++) rd();

    // Truncated packet: an early header in the body restarts packet tracking.
    for (int i = 0; i < 5; i++) wr(i == 0 || i == 2, pkt_t[i]);
    for (int i = 0; i < 5; i++) rd();

    // Asynchronous reset mid-packet, checked before the next clock edge.
    wr(1'b1, 8'h0D); wr(1'b0, 8'h91); rd();
    #2 reset = 1'b1;
    bus.write_enb = 0; bus.read_enb = 0;
    model_clear();
    #1 check_all();
    reset = 1'b0;
    @(negedge clock);
    wr(1'b0, 8'h92); wr(1'b1, 8'h04); wr(1'b0, 8'h93); wr(1'b0, 8'h94);
    for (int i = 0; i < 4; i++) rd();

    // Random traffic with short headers and rare flushes.
    for (int i = 0; i < 300; i++) begin
      bit         we, re, lfd, sr;
      int         hl;
      logic [W-1:0] din;
      we  = ($urandom_range(0, 99) < 55);
      re  = ($urandom_range(0, 99) < 50);
      lfd = ($urandom_range(0, 3) == 0);
      sr  = ($urandom_range(0, 59) == 0);
      hl  = $urandom_range(0, 4);
      din = lfd ? {hl[5:0], 2'b01} : 8'($urandom_range(0, 255));
      step(we, lfd, din, re, sr);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised, packet-aware FIFO for the router output channels. It replaces the fixed 8x16 channel FIFO. The block adds true DEPTH-entry full detection, almost-full backpressure, per-entry header tagging and packet-boundary tracking on the read side. It also adds a resident-packet count and sticky overflow/underflow flags. One instance sits between the router FSM/register (write side) and each destination port (read side).

Parameters:
WIDTH, 8, data word width in bits (>=4; header length field is data[WIDTH-1:2]).
DEPTH, 16, number of entries; power of two, >=4.
AFULL_LVL, 12, occupancy at or above which almost_full asserts (1..DEPTH-1).

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
soft_reset  in  1  synchronous flush (port timeout), active-high.
write_enb  in  1  write request.
lfd_state  in  1  data_in is a packet header (first word); qualified by write_enb.
data_in  in  WIDTH  write data.
read_enb  in  1  read request.
data_out  out  WIDTH  registered read data.
rd_valid  out  1  data_out updated by a pop this cycle.
rd_first  out  1  popped word was a header; valid with rd_valid.
rd_last  out  1  popped word ends its packet (parity word); valid with rd_valid.
full  out  1  occupancy == DEPTH.
empty  out  1  occupancy == 0.
almost_full  out  1  occupancy >= AFULL_LVL.
occupancy  out  clog2(DEPTH)+1  current entry count.
pkt_count  out  clog2(DEPTH)+1  headers written and not yet fully read.
overflow  out  1  sticky: write_enb while full.
underflow  out  1  sticky: read_enb while empty.

Behaviour:
- Storage: DEPTH x (WIDTH+1); the extra bit holds lfd_state at write time. There is no storage reset; contents are don't-care after reset or flush.
- Pointers are clog2(DEPTH) bits and wrap naturally. occupancy is a separate counter.
- Write accepted: write_enb && !full. Read accepted: read_enb && !empty. Both may occur in one cycle.
- Simultaneous accepted read and write: occupancy unchanged. At full, only the read is accepted; the write is dropped and overflow sets. At empty, only the write is accepted; underflow sets.
- full, empty, almost_full are combinational decodes of the occupancy register. There is no combinational path from the enables.
- Read latency is 1 cycle. data_out, rd_valid, rd_first and rd_last are all registered. data_out holds its last value when no pop occurs (no Z drive).
- Read FSM, two states:
  - HDR: expects a tagged word. On a pop of a tagged word, load remaining = data[WIDTH-1:2] + 1 (payload plus parity), assert rd_first, go to BODY.
  - BODY: each pop decrements remaining. The pop that takes remaining from 1 to 0 asserts rd_last and returns to HDR.
  - A tagged word popped in BODY is a truncated packet. It is treated as a new header: reload remaining, rd_first=1, no rd_last for the aborted packet.
  - An untagged word popped in HDR is passed through with rd_first=rd_last=0 and the FSM stays in HDR.
  - remaining is WIDTH-1 bits wide.
- pkt_count: +1 on an accepted tagged write, -1 on an rd_last pop, unchanged when both occur. Saturates at 0 and at DEPTH.
- soft_reset (synchronous) has priority over read/write in the same cycle. It clears pointers, occupancy, pkt_count, remaining, the FSM (to HDR), rd_valid/rd_first/rd_last and both sticky flags, and sets data_out=0.
- reset (asynchronous) has the same effect as soft_reset, applied immediately regardless of clock. Reset values: empty=1, full=0, almost_full=0, all counts 0, data_out=0, all flags 0.
- Reset asserted mid-packet leaves no residual state; the first post-reset pop is interpreted in HDR.

Optional Feature:
ROUTER_FIFO_PARITY_EN:
- Defined: each entry stores an extra even-parity bit computed over data_in at write. On pop, parity is recomputed, and a mismatch pulses output parity_err (registered, aligned with rd_valid) and sets sticky parity_err_seen. Both clear on reset/soft_reset.
- Undefined: no parity bit, ports parity_err and parity_err_seen absent, storage is WIDTH+1 wide.

Test Plan:
- Reset, then write header 8'h0D (len 3) plus 3 payload words plus 1 parity word, then read 5 -> data_out in order; rd_first on pop 1, rd_last on pop 5; pkt_count goes 1 then 0; empty=1.
- Write 16 words with DEPTH=16 -> full=1, occupancy=16, almost_full asserted from the 12th write; 17th write dropped, overflow=1, contents intact.
- At occupancy 16, assert write_enb and read_enb together -> read only, occupancy=15, overflow=1; at occupancy 8, both -> occupancy stays 8 and data order is preserved across pointer wrap.
- Read when empty -> underflow=1, data_out unchanged, rd_valid=0.
- Mid-packet with occupancy 6, pulse soft_reset together with write_enb -> next cycle occupancy=0, pkt_count=0, flags clear, write ignored; a subsequent header is read with rd_first=1.
- Header len 3 followed by an early header 8'h05 (len 1) -> second header popped in BODY reloads remaining=2, rd_first=1, no rd_last for the first packet.
